// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and validity helper for the up/down decade counter.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic bcd_valid(input logic [3:0] v);
    return (v <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: a 4-bit register with load, up/down step and ripple carry/borrow out.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       step_i,
  input  logic       up_dn_i,
  output logic [3:0] digit_o,
  output logic       step_o,
  output logic       load_bad_o
);

  bcd_digit_t digit_q, digit_d;

  assign load_bad_o = ~bcd_valid(load_val_i);

  // Carry/borrow ripples combinationally so all decades update on the same edge.
  assign step_o = step_i & (up_dn_i ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN));

  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_bad_o ? BCD_MIN : load_val_i;
    end else if (step_i) begin
      if (up_dn_i) begin
        digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      end else begin
        digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-decade synchronous BCD up/down counter with parallel load, terminal count and load error flag.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] d,
  output logic [4*NUM_DIGITS-1:0] q,
  output logic                    tc,
  output logic                    load_err
);

  logic [NUM_DIGITS:0]   step;
  logic [NUM_DIGITS-1:0] load_bad;
  logic                  load_err_q, load_err_d;

  assign step[0] = en & ~load;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .reset_i    (reset),
      .load_i     (load),
      .load_val_i (d[4*k +: 4]),
      .step_i     (step[k]),
      .up_dn_i    (up_dn),
      .digit_o    (q[4*k +: 4]),
      .step_o     (step[k+1]),
      .load_bad_o (load_bad[k])
    );
  end

  // Reset masks the carry chain output so tc never fires while the count is being cleared.
  assign tc = step[NUM_DIGITS] & ~reset;

  assign load_err_d = load & (|load_bad);

  always_ff @(posedge clk) begin
    if (reset) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed self-checking bench for bcd_updown_counter (4-digit main instance, 2-digit period instance).
module tb_bcd_updown_counter;

  logic        clk;
  logic        reset, en, up_dn, load;
  logic [15:0] d, q;
  logic        tc, load_err;

  logic        reset2, en2, up_dn2, load2;
  logic [7:0]  d2, q2;
  logic        tc2, load_err2;

  int checks;
  int failures;

  bcd_updown_counter #(.NUM_DIGITS(4)) u_dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .d(d), .q(q), .tc(tc), .load_err(load_err)
  );

  bcd_updown_counter #(.NUM_DIGITS(2)) u_dut2 (
    .clk(clk), .reset(reset2), .en(en2), .up_dn(up_dn2), .load(load2),
    .d(d2), .q(q2), .tc(tc2), .load_err(load_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; q is checked at the next falling edge, tc 1ns after the inputs settle.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; en = 1'b0; up_dn = 1'b1; d = '0;
    tick();
    reset = 1'b0;
    checks++;
    if (q !== 16'h0000) begin failures++; $display("FAIL reset_q: got %h expected 0000", q); end
    checks++;
    if (load_err !== 1'b0) begin failures++; $display("FAIL reset_load_err: got %b expected 0", load_err); end
  endtask

  task automatic test_up_wrap();
    reset = 1'b1; tick(); reset = 1'b0;
    load = 1'b1; d = 16'h9998; tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    #1;
    checks++;
    if (q !== 16'h9998 || tc !== 1'b0) begin failures++; $display("FAIL up_load9998: got q=%h tc=%b expected q=9998 tc=0", q, tc); end
    tick(); #1;
    checks++;
    if (q !== 16'h9999 || tc !== 1'b1) begin failures++; $display("FAIL up_9999: got q=%h tc=%b expected q=9999 tc=1", q, tc); end
    tick(); #1;
    checks++;
    if (q !== 16'h0000 || tc !== 1'b0) begin failures++; $display("FAIL up_wrap0000: got q=%h tc=%b expected q=0000 tc=0", q, tc); end
    tick(); #1;
    checks++;
    if (q !== 16'h0001 || tc !== 1'b0) begin failures++; $display("FAIL up_0001: got q=%h tc=%b expected q=0001 tc=0", q, tc); end
    en = 1'b0;
  endtask

  task automatic test_down_borrow();
    tick();
    load = 1'b1; d = 16'h1000; en = 1'b0; tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    #1;
    checks++;
    if (q !== 16'h1000 || tc !== 1'b0) begin failures++; $display("FAIL dn_load1000: got q=%h tc=%b expected q=1000 tc=0", q, tc); end
    tick(); #1;
    checks++;
    if (q !== 16'h0999 || tc !== 1'b0) begin failures++; $display("FAIL dn_0999: got q=%h tc=%b expected q=0999 tc=0", q, tc); end
    tick(); #1;
    checks++;
    if (q !== 16'h0998 || tc !== 1'b0) begin failures++; $display("FAIL dn_0998: got q=%h tc=%b expected q=0998 tc=0", q, tc); end
    load = 1'b1; d = 16'h0000; en = 1'b1;
    #1;
    checks++;
    if (tc !== 1'b0) begin failures++; $display("FAIL dn_tc_during_load: got %b expected 0", tc); end
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    #1;
    checks++;
    if (q !== 16'h0000 || tc !== 1'b1) begin failures++; $display("FAIL dn_0000_tc: got q=%h tc=%b expected q=0000 tc=1", q, tc); end
    tick(); #1;
    checks++;
    if (q !== 16'h9999 || tc !== 1'b0) begin failures++; $display("FAIL dn_wrap9999: got q=%h tc=%b expected q=9999 tc=0", q, tc); end
    en = 1'b0;
  endtask

  task automatic test_invalid_load();
    load = 1'b1; d = 16'h3A7F; tick();
    load = 1'b0;
    checks++;
    if (q !== 16'h3070) begin failures++; $display("FAIL inv_q: got %h expected 3070", q); end
    checks++;
    if (load_err !== 1'b1) begin failures++; $display("FAIL inv_err_set: got %b expected 1", load_err); end
    tick();
    checks++;
    if (load_err !== 1'b0 || q !== 16'h3070) begin failures++; $display("FAIL inv_err_one_cycle: got err=%b q=%h expected err=0 q=3070", load_err, q); end
    load = 1'b1; d = 16'h1234; tick();
    load = 1'b0;
    checks++;
    if (q !== 16'h1234 || load_err !== 1'b0) begin failures++; $display("FAIL valid_load: got q=%h err=%b expected q=1234 err=0", q, load_err); end
  endtask

  task automatic test_priority();
    // Reset with an invalid load and enable pending: everything cleared, no error flagged.
    reset = 1'b1; load = 1'b1; en = 1'b1; up_dn = 1'b1; d = 16'h00AA; tick();
    checks++;
    if (q !== 16'h0000 || load_err !== 1'b0) begin failures++; $display("FAIL prio_reset: got q=%h err=%b expected q=0000 err=0", q, load_err); end
    // q is 0000 and a down count is requested, but reset forces tc low.
    load = 1'b0; up_dn = 1'b0; en = 1'b1;
    #1;
    checks++;
    if (tc !== 1'b0) begin failures++; $display("FAIL prio_tc_in_reset: got %b expected 0", tc); end
    tick();
    reset = 1'b0; load = 1'b1; en = 1'b1; up_dn = 1'b1; d = 16'h0042; tick();
    load = 1'b0; en = 1'b0;
    checks++;
    if (q !== 16'h0042 || load_err !== 1'b0) begin failures++; $display("FAIL prio_load_over_en: got q=%h err=%b expected q=0042 err=0", q, load_err); end
  endtask

  task automatic test_hold_dir_change();
    logic held_ok;
    load = 1'b1; d = 16'h0059; tick();
    load = 1'b0; en = 1'b0; up_dn = 1'b1;
    held_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (q !== 16'h0059) held_ok = 1'b0;
    end
    checks++;
    if (!held_ok || q !== 16'h0059) begin failures++; $display("FAIL hold: got q=%h expected 0059 for 5 cycles", q); end
    en = 1'b1; up_dn = 1'b1; tick();
    checks++;
    if (q !== 16'h0060) begin failures++; $display("FAIL dir_up: got %h expected 0060", q); end
    up_dn = 1'b0; tick();
    checks++;
    if (q !== 16'h0059) begin failures++; $display("FAIL dir_down: got %h expected 0059", q); end
    up_dn = 1'b1; tick();
    checks++;
    if (q !== 16'h0060) begin failures++; $display("FAIL dir_up_again: got %h expected 0060", q); end
    en = 1'b0;
  endtask

  task automatic test_reset_midcount();
    load = 1'b1; d = 16'h0005; tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1; tick();
    reset = 1'b1; tick();
    checks++;
    if (q !== 16'h0000) begin failures++; $display("FAIL midreset_clear: got %h expected 0000", q); end
    reset = 1'b0; tick();
    checks++;
    if (q !== 16'h0001) begin failures++; $display("FAIL midreset_resume: got %h expected 0001", q); end
    en = 1'b0;
  endtask

  function automatic logic [7:0] to_bcd2(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic test_full_period();
    int   pulses;
    logic seq_ok;
    logic [7:0] exp_q;
    for (int dir = 1; dir >= 0; dir--) begin
      reset2 = 1'b1; tick();
      reset2 = 1'b0; en2 = 1'b1; up_dn2 = dir[0];
      pulses = 0; seq_ok = 1'b1;
      for (int unsigned i = 0; i < 100; i++) begin
        exp_q = (dir == 1) ? to_bcd2(i) : to_bcd2((100 - i) % 100);
        #1;
        if (q2 !== exp_q) seq_ok = 1'b0;
        if (tc2 === 1'b1) pulses++;
        tick();
      end
      en2 = 1'b0;
      checks++;
      if (!seq_ok) begin failures++; $display("FAIL period_seq_dir%0d: sequence diverged, final q=%h", dir, q2); end
      checks++;
      if (q2 !== 8'h00) begin failures++; $display("FAIL period_return_dir%0d: got %h expected 00", dir, q2); end
      checks++;
      if (pulses != 1) begin failures++; $display("FAIL period_tc_dir%0d: got %0d pulses expected 1", dir, pulses); end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset2 = 1'b1; en2 = 1'b0; up_dn2 = 1'b1; load2 = 1'b0; d2 = '0;
    test_reset();
    test_up_wrap();
    test_down_borrow();
    test_invalid_load();
    test_priority();
    test_hold_dir_change();
    test_reset_midcount();
    test_full_period();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
